// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a sub port for a-b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             inv_q, inv_d;

  logic bin;
  logic s;
  logic c;

  // B is inverted on its way into the cell when subtracting.
  assign bin = shb_q[0] ^ inv_q;
  assign s   = sha_q[0] ^ bin ^ carry_q;
  assign c   = (sha_q[0] & bin) | (sha_q[0] & carry_q) | (bin & carry_q);

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          inv_d   = sub;
          carry_d = sub;
`else
          inv_d   = 1'b0;
          carry_d = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        res_d   = {s, res_q[WIDTH-1:1]};
        carry_d = c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {s, res_q[WIDTH-1:1]};
          cout_d  = c;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      inv_q   <= inv_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == FIN);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8).
// Sub vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                       input logic vs, input logic [7:0] es,
                       input logic ec, input string tag);
    logic [7:0] prev;
    prev  = sum;
    a     = va;
    b     = vb;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = vs;
`else
    if (vs) $display("note: sub ignored in add-only build");
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    chk({tag, "_busy0"}, busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0 || sum !== prev)
        chk({tag, "_run"}, {busy, done, sum}, {1'b1, 1'b0, prev});
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busyF"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    tick();
    chk({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub      = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    do_op(8'd3, 8'd5, 1'b0, 8'd8, 1'b0, "add3_5");
    do_op(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, "add255_1");
    do_op(8'd200, 8'd100, 1'b0, 8'd44, 1'b1, "add200_100");

    // start held high; second start lands at edge 10
    a     = 8'd7;
    b     = 8'd9;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      if (k == 2) begin
        a = 8'd100;
        b = 8'd100;
      end
      tick();
      chk($sformatf("b2b_done_%0d", k), done, (k == 8 || k == 18));
      chk($sformatf("b2b_busy_%0d", k), busy,
          (k <= 7) || (k >= 10 && k <= 17));
      if (k == 8) begin
        chk("b2b_sum1", sum, 16);
        chk("b2b_cout1", cout, 0);
      end
      if (k == 18) begin
        chk("b2b_sum2", sum, 200);
        chk("b2b_cout2", cout, 0);
      end
    end
    start = 1'b0;
    tick();
    tick();
    chk("b2b_idle", busy, 0);

    // reset in the middle of a run
    a     = 8'd50;
    b     = 8'd60;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_sum", sum, 0);
    chk("mid_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0)
        chk("mid_nodone", {done, busy}, 0);
    end
    chk("mid_quiet", done, 0);
    do_op(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, "post_rst");

    do_op(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, "add10_20");
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0 || sum !== 8'd30)
        chk("hold", {done, sum}, {1'b0, 8'd30});
    end
    chk("hold_sum", sum, 30);
    chk("hold_done", done, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'd5, 8'd3, 1'b1, 8'd2, 1'b1, "sub5_3");
    do_op(8'd3, 8'd5, 1'b1, 8'd254, 1'b0, "sub3_5");
    do_op(8'd3, 8'd5, 1'b0, 8'd8, 1'b0, "add_sub0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that shifts two WIDTH-bit operands LSB-first through a 1-bit full-add cell.
- A carry flip-flop chains each bit's carry into the next bit.
- Sits upstream of the combinational half/full-adder lab cells: it sequences operands into the cell and collects the sum.
- Uses a start/busy/done handshake. Serves as the first clocked datapath exercise of the lab set.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request: load a/b and begin addition; sampled only in IDLE.
- a  in  WIDTH  operand A, captured on the accepted start edge.
- b  in  WIDTH  operand B, captured on the accepted start edge.
- busy  out  1  high while bits are being processed (RUN state).
- done  out  1  one-cycle pulse: result valid and newly updated.
- sum  out  WIDTH  result register (a+b mod 2^WIDTH); holds until the next completion.
- cout  out  1  carry out of the MSB; holds with sum.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry FF and bit counter cleared. Reset mid-RUN aborts the operation; sum and cout go to 0, no done.
- States: IDLE, RUN, FIN.
- IDLE: if start=1 at an edge, load shA<=a, shB<=b, carry<=0, cnt<=0, state<=RUN. Otherwise stay.
- RUN (busy=1): each edge does the following:
  - s = shA[0]^shB[0]^carry; carry <= majority(shA[0],shB[0],carry).
  - shA, shB shift right by 1; s enters the MSB of the result shift register; cnt <= cnt+1.
  - After the edge that processes bit WIDTH-1 (cnt==WIDTH-1): sum <= completed result, cout <= final carry, state <= FIN.
- FIN: done=1, busy=0 for exactly one cycle; next edge returns to IDLE.
- Latency: start accepted at edge 0 → bits processed at edges 1..WIDTH → done high in the cycle after edge WIDTH → IDLE after edge WIDTH+1.
- Back-to-back: start is accepted earliest at edge WIDTH+2, giving a throughput of 1 result per WIDTH+2 cycles.
- start in RUN or FIN is ignored; a and b may change freely after capture without affecting the result.
- sum and cout update only when entering FIN. Intermediate shift state is not visible on sum.
- Counter width: clog2(WIDTH)+1 bits; no wrap inside one operation.
- Outputs are fully registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (in, 1), captured with the operands on the start edge.
  - sub=1: B bits are inverted as they enter the adder and the carry FF is initialised to 1, so sum = a-b mod 2^WIDTH and cout = 1 when no borrow (a>=b), 0 when borrow.
  - sub=0: identical to addition.
- Not defined: no sub port; addition only; carry always initialised to 0.

Test Plan:
- WIDTH=8, a=3, b=5, start pulsed at edge 0 → busy high for edges 1..8, done=1 for one cycle after edge 8, sum=8, cout=0.
- a=255, b=1 → sum=0, cout=1; a=200, b=100 → sum=44, cout=1.
- start held high throughout, with a/b changed mid-RUN → first result unaffected; second start accepted at edge 10 (WIDTH+2), done pulses every 10 cycles.
- rst_n driven low at edge 4 of a run → busy, done, sum and cout immediately 0, state IDLE; no done pulse follows; a new start completes normally.
- After a=10, b=20 result, idle for 20 cycles → sum=30 stable, done low throughout.
- With SERIAL_ADDER_SUB_EN: sub=1, a=5, b=3 → sum=2, cout=1; sub=1, a=3, b=5 → sum=254, cout=0; sub=0, a=3, b=5 → sum=8.
